// File: rtl/eq32_pkg.sv
// Shared constants for the chunked 32-bit equality sequencer: FSM encoding,
// chunk geometry and the width of the zero padding on the top chunk.
package eq32_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NCHUNK  = 6;
  localparam int unsigned CHUNK_W = 6;
  localparam int unsigned IDX_W   = 3;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // The top chunk holds the leftover operand bits; the rest is zero padding.
  function automatic int unsigned pad_w();
    return NCHUNK * CHUNK_W - DATA_W;
  endfunction

endpackage

// File: rtl/eq32_chunk_sel.sv
// Combinational chunk mux: picks 6-bit chunk idx out of a 32-bit operand,
// with the top chunk zero-extended.
module eq32_chunk_sel
  import eq32_pkg::*;
(
  input  logic [DATA_W-1:0]  x,
  input  logic [IDX_W-1:0]   idx,
  output logic [CHUNK_W-1:0] chunk
);

  localparam int unsigned PAD_W = pad_w();

  always_comb begin
    chunk = '0;
    case (idx)
      3'd0: chunk = x[5:0];
      3'd1: chunk = x[11:6];
      3'd2: chunk = x[17:12];
      3'd3: chunk = x[23:18];
      3'd4: chunk = x[29:24];
      3'd5: chunk = {{PAD_W{1'b0}}, x[DATA_W-1:(NCHUNK-1)*CHUNK_W]};
      default: chunk = '0;
    endcase
  end

endmodule

// File: rtl/xnor_gate_6to1.sv
// 6-bit equality comparator cell: y=1 when all six bit pairs match.
module xnor_gate_6to1 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic       y
);

  assign y = &(a ~^ b);

endmodule

// File: rtl/eq32_seq_ctrl.sv
// Time-multiplexed 32-bit equality check over six 6-bit chunks sharing one
// comparator; start/busy/done handshake with optional early exit on mismatch.
module eq32_seq_ctrl
  import eq32_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              eq,
  output logic [IDX_W-1:0]  chunks
);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic               mism_q, mism_d;
  logic               eq_q, eq_d;
  logic [IDX_W-1:0]   chunks_q, chunks_d;

  logic [CHUNK_W-1:0] chunk_a, chunk_b;
  logic               chunk_eq;

  eq32_chunk_sel u_sel_a (.x(a_q), .idx(idx_q), .chunk(chunk_a));
  eq32_chunk_sel u_sel_b (.x(b_q), .idx(idx_q), .chunk(chunk_b));

  xnor_gate_6to1 u_cmp (.a(chunk_a), .b(chunk_b), .y(chunk_eq));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    mism_d   = mism_q;
    eq_d     = eq_q;
    chunks_d = chunks_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          idx_d    = '0;
          mism_d   = 1'b0;
          eq_d     = 1'b0;
          chunks_d = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (EARLY_EXIT && !chunk_eq) begin
          eq_d     = 1'b0;
          chunks_d = idx_q + IDX_W'(1);
          state_d  = ST_DONE;
        end else if (idx_q == LAST_IDX) begin
          // Fold in the last chunk directly; the sticky flag lags by one.
          eq_d     = !(mism_q || !chunk_eq);
          chunks_d = IDX_W'(NCHUNK);
          state_d  = ST_DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          mism_d   = mism_q | !chunk_eq;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mism_q   <= 1'b0;
      eq_q     <= 1'b0;
      chunks_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mism_q   <= mism_d;
      eq_q     <= eq_d;
      chunks_q <= chunks_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign eq     = eq_q;
  assign chunks = chunks_q;

endmodule

// File: tb/tb_eq32_seq_ctrl.sv
// Directed bench for eq32_seq_ctrl: one instance with early exit, one without,
// driven by the same stimulus and checked cycle by cycle.
module tb_eq32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic       busy1, done1, eq1;
  logic [2:0] chunks1;
  logic       busy0, done0, eq0;
  logic [2:0] chunks0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eq32_seq_ctrl #(.EARLY_EXIT(1'b1)) dut_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .eq(eq1), .chunks(chunks1)
  );

  eq32_seq_ctrl #(.EARLY_EXIT(1'b0)) dut_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .eq(eq0), .chunks(chunks0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    total++;
    if ({busy1, done1, eq1, chunks1} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ee1: got busy=%b done=%b eq=%b chunks=%0d, want all 0", busy1, done1, eq1, chunks1);
    end
    total++;
    if ({busy0, done0, eq0, chunks0} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ee0: got busy=%b done=%b eq=%b chunks=%0d, want all 0", busy0, done0, eq0, chunks0);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({busy1, done1, busy0, done0} !== 4'b0) begin
      bad++;
      $display("FAIL reset_release: got busy1/done1/busy0/done0=%b, want 0000", {busy1, done1, busy0, done0});
    end
  endtask

  // Single compare: d1/d0 are the done cycles, results held from then on.
  task automatic test_single(input string name, input logic [31:0] va, input logic [31:0] vb,
                             input int d1, input logic q1, input logic [2:0] c1,
                             input int d0, input logic q0, input logic [2:0] c0);
    logic       eb, ed, eq_e;
    logic [2:0] ch_e;
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      eb = (cyc < d1); ed = (cyc == d1);
      eq_e = (cyc >= d1) ? q1 : 1'b0;
      ch_e = (cyc >= d1) ? c1 : 3'd0;
      total++;
      if ({busy1, done1, eq1, chunks1} !== {eb, ed, eq_e, ch_e}) begin
        bad++;
        $display("FAIL %s_ee1 c%0d: got busy=%b done=%b eq=%b chunks=%0d, want busy=%b done=%b eq=%b chunks=%0d",
                 name, cyc, busy1, done1, eq1, chunks1, eb, ed, eq_e, ch_e);
      end
      eb = (cyc < d0); ed = (cyc == d0);
      eq_e = (cyc >= d0) ? q0 : 1'b0;
      ch_e = (cyc >= d0) ? c0 : 3'd0;
      total++;
      if ({busy0, done0, eq0, chunks0} !== {eb, ed, eq_e, ch_e}) begin
        bad++;
        $display("FAIL %s_ee0 c%0d: got busy=%b done=%b eq=%b chunks=%0d, want busy=%b done=%b eq=%b chunks=%0d",
                 name, cyc, busy0, done0, eq0, chunks0, eb, ed, eq_e, ch_e);
      end
      tick();
    end
  endtask

  task automatic test_full_equal();
    test_single("full_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 7, 1'b1, 3'd6, 7, 1'b1, 3'd6);
  endtask

  task automatic test_early_exit();
    test_single("early_exit", 32'h0000_0000, 32'h0000_0040, 3, 1'b0, 3'd2, 7, 1'b0, 3'd6);
  endtask

  task automatic test_padded_chunk();
    test_single("padded", 32'h4000_0000, 32'h0000_0000, 7, 1'b0, 3'd6, 7, 1'b0, 3'd6);
  endtask

  task automatic test_back_to_back();
    logic       eb, ed, eq_e;
    logic [2:0] ch_e;
    a = 32'hCAFE_F00D;
    b = 32'hCAFE_F00D;
    start = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 15; cyc++) begin
      if (cyc == 1) begin
        a = 32'h0000_0001;
        b = 32'h0000_0000;
      end
      if (cyc == 8) begin
        start = 1'b0;
        a = 32'h0000_0000;
        b = 32'h0000_0000;
      end
      eb = (cyc <= 6) || (cyc == 8);
      ed = (cyc == 7) || (cyc == 9);
      eq_e = (cyc == 7);
      ch_e = (cyc == 7) ? 3'd6 : ((cyc >= 9) ? 3'd1 : 3'd0);
      total++;
      if ({busy1, done1, eq1, chunks1} !== {eb, ed, eq_e, ch_e}) begin
        bad++;
        $display("FAIL b2b_ee1 c%0d: got busy=%b done=%b eq=%b chunks=%0d, want busy=%b done=%b eq=%b chunks=%0d",
                 cyc, busy1, done1, eq1, chunks1, eb, ed, eq_e, ch_e);
      end
      eb = (cyc <= 6) || (cyc >= 8 && cyc <= 13);
      ed = (cyc == 7) || (cyc == 14);
      eq_e = (cyc == 7);
      ch_e = (cyc == 7 || cyc >= 14) ? 3'd6 : 3'd0;
      total++;
      if ({busy0, done0, eq0, chunks0} !== {eb, ed, eq_e, ch_e}) begin
        bad++;
        $display("FAIL b2b_ee0 c%0d: got busy=%b done=%b eq=%b chunks=%0d, want busy=%b done=%b eq=%b chunks=%0d",
                 cyc, busy0, done0, eq0, chunks0, eb, ed, eq_e, ch_e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    logic eb;
    a = 32'h0F0F_0F0F;
    b = 32'h0F0F_0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 3) rst_n = 1'b0;
      if (cyc == 4) rst_n = 1'b1;
      eb = (cyc <= 3);
      total++;
      if ({busy1, done1, busy0, done0} !== {eb, 1'b0, eb, 1'b0}) begin
        bad++;
        $display("FAIL abort c%0d: got busy1/done1/busy0/done0=%b, want %b",
                 cyc, {busy1, done1, busy0, done0}, {eb, 1'b0, eb, 1'b0});
      end
      if (cyc >= 4) begin
        total++;
        if ({eq1, chunks1, eq0, chunks0} !== 8'b0) begin
          bad++;
          $display("FAIL abort_result c%0d: got eq1=%b chunks1=%0d eq0=%b chunks0=%0d, want all 0",
                   cyc, eq1, chunks1, eq0, chunks0);
        end
      end
      tick();
    end
    a = 32'h8000_0001;
    b = 32'h8000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) tick();
    total++;
    if ({done1, eq1, chunks1, done0, eq0, chunks0} !== {1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 3'd6}) begin
      bad++;
      $display("FAIL restart: got done1=%b eq1=%b chunks1=%0d done0=%b eq0=%b chunks0=%0d, want 1 1 6 1 1 6",
               done1, eq1, chunks1, done0, eq0, chunks0);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy1, done1, eq1, chunks1, busy0, done0, eq0, chunks0} !== 12'b0) begin
      bad++;
      $display("FAIL reset_in_done: got ee1 busy=%b done=%b eq=%b chunks=%0d ee0 busy=%b done=%b eq=%b chunks=%0d, want all 0",
               busy1, done1, eq1, chunks1, busy0, done0, eq0, chunks0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_equal();
    test_early_exit();
    test_padded_chunk();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
